ahb_src_slave_if: RTL and testbench

- AHB-Lite slave front end for the source clock domain of the AHB2AHB bridge.
- Converts AHB address/data-phase transfers into single-request valid/ready commands for the source controller, which packs them into the request FIFO.
- Stalls the AHB data phase with HREADYOUT until the write is accepted or the read response returns.
- Sits directly upstream of the source controller.

---
 rtl/ahb_src_slave_if_if.sv | 41 ++++
 rtl/ahb_src_slave_if.sv | 150 +++++++++++++++
 tb/tb_ahb_src_slave_if.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_src_slave_if_if.sv
// Bus bundle for the AHB2AHB source-side slave front end: AHB-Lite slave
// signals plus the single-command valid/ready link to the source controller.
interface ahb_src_slave_if_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  // AHB-Lite slave side
  logic                  i_hsel;
  logic [1:0]            i_htrans;
  logic                  i_hwrite;
  logic [ADDR_WIDTH-1:0] i_haddr;
  logic [2:0]            i_hsize;
  logic [DATA_WIDTH-1:0] i_hwdata;
  logic                  i_hready;
  logic                  o_hreadyout;
  logic                  o_hresp;
  logic [DATA_WIDTH-1:0] o_hrdata;

  // Command link to the source controller
  logic                  o_rd0_wr1;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_wr_data;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] i_rd_data;
  logic                  i_rd_valid;

  modport slave (
    input  i_hsel, i_htrans, i_hwrite, i_haddr, i_hsize, i_hwdata, i_hready,
    input  i_ready, i_rd_data, i_rd_valid,
    output o_hreadyout, o_hresp, o_hrdata,
    output o_rd0_wr1, o_addr, o_valid, o_wr_data
  );

  modport master (
    output i_hsel, i_htrans, i_hwrite, i_haddr, i_hsize, i_hwdata, i_hready,
    output i_ready, i_rd_data, i_rd_valid,
    input  o_hreadyout, o_hresp, o_hrdata,
    input  o_rd0_wr1, o_addr, o_valid, o_wr_data
  );
endinterface

// File: rtl/ahb_src_slave_if.sv
// AHB-Lite slave front end for the source clock domain of the AHB2AHB bridge.
// Turns each accepted AHB transfer into one valid/ready command for the source
// controller and stalls the data phase until the write is taken or the read
// data returns. Illegal size/alignment gets a two-cycle ERROR response.
// Optional read-response timeout: define AHB_SRC_TIMEOUT_EN.
module ahb_src_slave_if #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic               i_clk_src,
  input logic               i_rstn_src,
  ahb_src_slave_if_if.slave bus
);

  localparam int unsigned MAX_SIZE = $clog2(DATA_WIDTH / 8);
  localparam int unsigned CNT_W    = $clog2(TIMEOUT_CYCLES + 1);

`ifdef AHB_SRC_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  // Counter below has no observable effect and is pruned in this build.
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_DATA,
    S_WR_PUSH,
    S_RD_REQ,
    S_RD_WAIT,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  logic                  active_c;
  logic                  accept_c;
  logic                  size_err_c;
  logic                  align_err_c;
  logic                  timeout_c;
  logic [ADDR_WIDTH-1:0] align_mask_c;

  // Address-phase qualification and legality of the requested transfer
  assign active_c     = bus.i_hsel && bus.i_hready &&
                        (bus.i_htrans == 2'b10 || bus.i_htrans == 2'b11);
  assign accept_c     = active_c && (state == S_IDLE);
  assign size_err_c   = bus.i_hsize > 3'(MAX_SIZE);
  assign align_mask_c = ~({ADDR_WIDTH{1'b1}} << bus.i_hsize);
  assign align_err_c  = |(bus.i_haddr & align_mask_c);

  // Timeout fires on the edge that would bring the count to TIMEOUT_CYCLES
  assign timeout_c = TIMEOUT_EN && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Transfer FSM with registered bus and command outputs
  always_ff @(posedge i_clk_src) begin
    if (!i_rstn_src) begin
      state           <= S_IDLE;
      wait_cnt        <= '0;
      bus.o_hreadyout <= 1'b1;
      bus.o_hresp     <= 1'b0;
      bus.o_hrdata    <= '0;
      bus.o_valid     <= 1'b0;
      bus.o_rd0_wr1   <= 1'b1;
      bus.o_addr      <= '0;
      bus.o_wr_data   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            bus.o_hreadyout <= 1'b0;
            if (size_err_c || align_err_c) begin
              bus.o_hresp <= 1'b1;
              state       <= S_ERR1;
            end else begin
              bus.o_addr <= bus.i_haddr;
              if (bus.i_hwrite) begin
                state <= S_WR_DATA;
              end else begin
                bus.o_valid   <= 1'b1;
                bus.o_rd0_wr1 <= 1'b0;
                state         <= S_RD_REQ;
              end
            end
          end
        end

        // Write data is only valid in the data phase, one cycle after accept
        S_WR_DATA: begin
          bus.o_wr_data <= bus.i_hwdata;
          bus.o_valid   <= 1'b1;
          state         <= S_WR_PUSH;
        end

        S_WR_PUSH: begin
          if (bus.i_ready) begin
            bus.o_valid     <= 1'b0;
            bus.o_hreadyout <= 1'b1;
            state           <= S_IDLE;
          end
        end

        S_RD_REQ: begin
          if (bus.i_ready) begin
            bus.o_valid <= 1'b0;
            wait_cnt    <= '0;
            state       <= S_RD_WAIT;
          end
        end

        // A response arriving on the timeout edge still wins
        S_RD_WAIT: begin
          if (bus.i_rd_valid) begin
            bus.o_hrdata    <= bus.i_rd_data;
            bus.o_hreadyout <= 1'b1;
            bus.o_rd0_wr1   <= 1'b1;
            state           <= S_IDLE;
          end else if (timeout_c) begin
            bus.o_rd0_wr1 <= 1'b1;
            bus.o_hresp   <= 1'b1;
            state         <= S_ERR1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        S_ERR1: begin
          bus.o_hreadyout <= 1'b1;
          state           <= S_ERR2;
        end

        S_ERR2: begin
          bus.o_hresp <= 1'b0;
          state       <= S_IDLE;
        end

        default: begin
          bus.o_hreadyout <= 1'b1;
          bus.o_hresp     <= 1'b0;
          bus.o_valid     <= 1'b0;
          bus.o_rd0_wr1   <= 1'b1;
          state           <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_src_slave_if.sv
// Self-checking bench for ahb_src_slave_if: directed vector table, randomized
// transfers against a transaction-level model, and hand-written sequences
// for reset during a read and the read-response timeout.
`timescale 1ns/1ps
module tb_ahb_src_slave_if;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ahb_src_slave_if_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ahb_src_slave_if #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk_src (clk),
    .i_rstn_src(rstn),
    .bus       (bus)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          rdy_dly;
    int          rd_dly;
    logic [31:0] rdata;
    bit          b2b;
    int          exp_low;
    int          exp_valid;
    logic        exp_resp;
    logic [31:0] exp_hrdata;
  } vec_t;

  localparam int NVEC = 9;
  vec_t tbl [NVEC];

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] last_rd = 32'h0;

  // Per-transfer observations
  int          obs_low, obs_valid, obs_resp_stall;
  bit          obs_done, obs_payload_ok;
  logic        obs_hresp, obs_rd0_wr1;
  logic [31:0] obs_hrdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Spec rules: size wider than the bus, or address not aligned to the size
  function automatic bit model_err(input logic [2:0] size, input logic [31:0] addr);
    logic [31:0] bytes;
    bytes = 32'd1 << size;
    return (size > 3'd2) || ((addr % bytes) != 32'd0);
  endfunction

  function automatic int model_low(input bit err, input logic wr, input int rdy, input int rdd);
    if (err) return 1;
    if (wr)  return rdy + 2;
    return rdy + rdd + 2;
  endfunction

  // Drive one transfer from the current negedge; returns at the negedge
  // where hreadyout is seen high again.
  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata, input int rdy_dly, input int rd_dly,
                          input logic [31:0] rdata, input bit noise);
    int vcnt = 0;
    int wcnt = 0;
    bit in_wait = 1'b0;
    logic hro, valid, rdv;
    obs_low = 0; obs_resp_stall = 0; obs_done = 1'b0; obs_payload_ok = 1'b1;
    bus.i_hsel = 1'b1; bus.i_htrans = 2'b10; bus.i_hwrite = wr;
    bus.i_haddr = addr; bus.i_hsize = size; bus.i_hready = 1'b1;
    bus.i_ready = 1'b0; bus.i_rd_valid = 1'b0;
    @(posedge clk);
    for (int cyc = 0; cyc < 64 && !obs_done; cyc++) begin
      @(negedge clk);
      hro   = bus.o_hreadyout;
      valid = bus.o_valid;
      if (!hro) begin
        obs_low++;
        if (bus.o_hresp) obs_resp_stall++;
      end
      if (valid) begin
        vcnt++;
        if (bus.o_addr !== addr || bus.o_rd0_wr1 !== wr || (wr && bus.o_wr_data !== wdata))
          obs_payload_ok = 1'b0;
      end
      if (in_wait && !hro && bus.o_rd0_wr1 !== 1'b0) obs_payload_ok = 1'b0;
      if (cyc == 0) begin
        bus.i_htrans = 2'b00;
        bus.i_hwdata = wdata;
      end else if (noise) begin
        bus.i_hwdata = $urandom;
      end
      if (noise) begin
        bus.i_hsel   = 1'($urandom);
        bus.i_hwrite = 1'($urandom);
        bus.i_haddr  = $urandom;
      end else begin
        bus.i_hsel = 1'b0;
      end
      if (hro) begin
        obs_done    = 1'b1;
        obs_hresp   = bus.o_hresp;
        obs_hrdata  = bus.o_hrdata;
        obs_rd0_wr1 = bus.o_rd0_wr1;
      end else begin
        bus.i_ready = valid ? (vcnt > rdy_dly) : (noise ? 1'($urandom) : 1'b0);
        if (in_wait) begin
          wcnt++;
          rdv = (wcnt > rd_dly);
        end else begin
          rdv = noise ? 1'($urandom) : 1'b0;
        end
        bus.i_rd_valid = rdv;
        bus.i_rd_data  = (in_wait && rdv) ? rdata : $urandom;
        if (valid && bus.i_ready && !wr) in_wait = 1'b1;
      end
    end
    obs_valid = vcnt;
  endtask

  task automatic check_xfer(input string tag, input int exp_low, input int exp_valid,
                            input logic exp_resp, input logic [31:0] exp_hrdata);
    check({tag, "_done"},       64'(obs_done), 64'(1));
    check({tag, "_low"},        64'(obs_low), 64'(exp_low));
    check({tag, "_valid_cyc"},  64'(obs_valid), 64'(exp_valid));
    check({tag, "_payload"},    64'(obs_payload_ok), 64'(1));
    check({tag, "_resp_stall"}, 64'(obs_resp_stall), 64'(exp_resp));
    check({tag, "_hresp"},      64'(obs_hresp), 64'(exp_resp));
    check({tag, "_hrdata"},     64'(obs_hrdata), 64'(exp_hrdata));
    check({tag, "_dir_idle"},   64'(obs_rd0_wr1), 64'(1));
  endtask

  // One cycle of IDLE or BUSY: must be a zero-wait OKAY with no command
  task automatic idle_check(input string tag);
    bus.i_hsel     = 1'b1;
    bus.i_htrans   = ($urandom % 2 == 0) ? 2'b00 : 2'b01;
    bus.i_ready    = 1'b0;
    bus.i_rd_valid = 1'b0;
    @(negedge clk);
    check({tag, "_idle_hready"}, 64'(bus.o_hreadyout), 64'(1));
    check({tag, "_idle_hresp"},  64'(bus.o_hresp), 64'(0));
    check({tag, "_idle_valid"},  64'(bus.o_valid), 64'(0));
  endtask

  initial begin
    int low, vcnt;
    bit done, prev_err;

    bus.i_hsel = 1'b0; bus.i_htrans = 2'b00; bus.i_hwrite = 1'b0; bus.i_haddr = '0;
    bus.i_hsize = 3'd0; bus.i_hwdata = '0; bus.i_hready = 1'b1;
    bus.i_ready = 1'b0; bus.i_rd_data = '0; bus.i_rd_valid = 1'b0;

    //           wr    addr          sz    wdata         rdy rdd rdata         b2b   low val resp  hrdata
    tbl[0] = '{1'b1, 32'h1000_0004, 3'd2, 32'hDEAD_BEEF, 0, 0, 32'h0,         1'b0, 2, 1, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 32'h1000_0004, 3'd2, 32'hDEAD_BEEF, 5, 0, 32'h0,         1'b0, 7, 6, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 32'h0000_0020, 3'd2, 32'h0,         0, 3, 32'h1234_5678, 1'b1, 5, 1, 1'b0, 32'h1234_5678};
    tbl[3] = '{1'b1, 32'h0000_0000, 3'd3, 32'h1111_1111, 0, 0, 32'h0,         1'b0, 1, 0, 1'b1, 32'h1234_5678};
    tbl[4] = '{1'b0, 32'h0000_0002, 3'd2, 32'h0,         0, 0, 32'h0,         1'b0, 1, 0, 1'b1, 32'h1234_5678};
    tbl[5] = '{1'b0, 32'h0000_0003, 3'd0, 32'h0,         2, 0, 32'hA5A5_0001, 1'b0, 4, 3, 1'b0, 32'hA5A5_0001};
    tbl[6] = '{1'b1, 32'h0000_0006, 3'd1, 32'h0000_BEEF, 1, 0, 32'h0,         1'b1, 3, 2, 1'b0, 32'hA5A5_0001};
    tbl[7] = '{1'b1, 32'h0000_0005, 3'd1, 32'h2222_2222, 0, 0, 32'h0,         1'b0, 1, 0, 1'b1, 32'hA5A5_0001};
    tbl[8] = '{1'b0, 32'h0000_0000, 3'd7, 32'h0,         0, 0, 32'h0,         1'b0, 1, 0, 1'b1, 32'hA5A5_0001};

    // Power-on reset values
    repeat (3) @(negedge clk);
    check("rst_hreadyout", 64'(bus.o_hreadyout), 64'(1));
    check("rst_hresp",     64'(bus.o_hresp), 64'(0));
    check("rst_hrdata",    64'(bus.o_hrdata), 64'(0));
    check("rst_valid",     64'(bus.o_valid), 64'(0));
    check("rst_rd0_wr1",   64'(bus.o_rd0_wr1), 64'(1));
    check("rst_addr",      64'(bus.o_addr), 64'(0));
    check("rst_wr_data",   64'(bus.o_wr_data), 64'(0));
    rstn = 1'b1;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < NVEC; i++) begin
      if (!tbl[i].b2b) idle_check($sformatf("tbl%0d", i));
      run_xfer(tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].wdata,
               tbl[i].rdy_dly, tbl[i].rd_dly, tbl[i].rdata, 1'b0);
      check_xfer($sformatf("tbl%0d", i), tbl[i].exp_low, tbl[i].exp_valid,
                 tbl[i].exp_resp, tbl[i].exp_hrdata);
      last_rd = tbl[i].exp_hrdata;
    end

    // Randomized transfers against the transaction model
    prev_err = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic        wr;
      logic [2:0]  size;
      logic [31:0] addr, wdata, rdata;
      int          rdy, rdd;
      bit          err;
      wr    = 1'($urandom);
      size  = ($urandom % 8 < 6) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      addr  = $urandom;
      if ($urandom % 4 != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      wdata = $urandom;
      rdata = $urandom;
      rdy   = $urandom_range(0, 4);
      rdd   = $urandom_range(0, 5);
      err   = model_err(size, addr);
      if (prev_err || ($urandom % 2 == 0)) idle_check($sformatf("rnd%0d", i));
      run_xfer(wr, addr, size, wdata, rdy, rdd, rdata, 1'b1);
      if (!err && !wr) last_rd = rdata;
      check_xfer($sformatf("rnd%0d", i), model_low(err, wr, rdy, rdd),
                 err ? 0 : rdy + 1, err, last_rd);
      prev_err = err;
    end
    idle_check("pre_rst");

    // Reset held for three edges while waiting for read data
    bus.i_hsel = 1'b1; bus.i_htrans = 2'b10; bus.i_hwrite = 1'b0;
    bus.i_haddr = 32'h40; bus.i_hsize = 3'd2;
    @(negedge clk);
    check("rstseq_req_valid", 64'(bus.o_valid), 64'(1));
    bus.i_hsel = 1'b0; bus.i_htrans = 2'b00; bus.i_ready = 1'b1;
    @(negedge clk);
    check("rstseq_wait_dir",    64'(bus.o_rd0_wr1), 64'(0));
    check("rstseq_wait_hready", 64'(bus.o_hreadyout), 64'(0));
    bus.i_ready = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    check("rstseq_hready",  64'(bus.o_hreadyout), 64'(1));
    check("rstseq_valid",   64'(bus.o_valid), 64'(0));
    check("rstseq_rd0_wr1", 64'(bus.o_rd0_wr1), 64'(1));
    check("rstseq_hrdata",  64'(bus.o_hrdata), 64'(0));
    check("rstseq_wr_data", 64'(bus.o_wr_data), 64'(0));
    bus.i_rd_valid = 1'b1; bus.i_rd_data = 32'hCAFE_F00D;
    @(negedge clk);
    bus.i_rd_valid = 1'b0;
    check("rstseq_late_hrdata", 64'(bus.o_hrdata), 64'(0));
    check("rstseq_late_hready", 64'(bus.o_hreadyout), 64'(1));
    last_rd = 32'h0;
    idle_check("post_rst");

    // Read whose response never arrives
    bus.i_hsel = 1'b1; bus.i_htrans = 2'b10; bus.i_hwrite = 1'b0;
    bus.i_haddr = 32'h80; bus.i_hsize = 3'd2;
    low = 0; vcnt = 0; done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (bus.o_hreadyout) done = 1'b1;
      else low++;
      if (bus.o_valid) vcnt++;
      if (c == 0) begin
        bus.i_hsel = 1'b0; bus.i_htrans = 2'b00;
      end
      bus.i_ready = bus.o_valid;
    end
    check("tmo_valid_cyc", 64'(vcnt), 64'(1));
`ifdef AHB_SRC_TIMEOUT_EN
    check("tmo_done",   64'(done), 64'(1));
    check("tmo_low",    64'(low), 64'(TO + 2));
    check("tmo_hresp",  64'(bus.o_hresp), 64'(1));
    check("tmo_hrdata", 64'(bus.o_hrdata), 64'(last_rd));
    idle_check("tmo_after");
`else
    check("tmo_done", 64'(done), 64'(0));
    check("tmo_low",  64'(low), 64'(20));
    bus.i_ready = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    idle_check("tmo_after_rst");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  // Safety net against a stuck sequence
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
